// File: rtl/stopwatch_display_driver.sv
`default_nettype none
// ============================================================================
// Module      : stopwatch_display_driver
// Description : Drives a 4-digit multiplexed seven-segment display (MM.SS)
//               from binary minutes/seconds. Inputs are shadowed once per
//               frame, out-of-range fields show dashes, and the whole display
//               blinks while the finish flag is high.
// Revision    : 1.0 - initial release
// ============================================================================
module stopwatch_display_driver #(
  parameter int SCAN_DIV     = 4,
  parameter int BLINK_DIV    = 16,
  parameter int COMMON_ANODE = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] in_minutes,
  input  logic [5:0] in_seconds,
  input  logic       finish,
  output logic [6:0] seg,
  output logic       dp,
  output logic [3:0] an
);

  localparam int DIV_W   = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam int BLINK_W = (BLINK_DIV > 2) ? $clog2(BLINK_DIV) : 1;
  localparam logic [DIV_W-1:0]   DIV_LAST   = DIV_W'(SCAN_DIV - 1);
  localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_DIV - 1);
  // Output polarity: all-ones mask when the display is common-anode.
  localparam logic POL = (COMMON_ANODE != 0) ? 1'b1 : 1'b0;

  logic [DIV_W-1:0]   div_cnt;
  logic [1:0]         digit_idx;
  logic [5:0]         sh_min;
  logic [5:0]         sh_sec;
  logic               fin_q;
  logic [BLINK_W-1:0] blink_cnt;
  logic               blink_on;

  logic               frame_end;
  logic [5:0]         field;
  logic [5:0]         tens_val;
  logic [5:0]         ones_val;
  logic [5:0]         digit_val;
  logic [6:0]         seg_next;
  logic               dp_next;
  logic [3:0]         an_next;

  assign frame_end = (div_cnt == DIV_LAST) && (digit_idx == 2'd3);

  // Scan timing: each digit stays enabled for SCAN_DIV cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt   <= '0;
      digit_idx <= 2'd0;
    end else if (div_cnt == DIV_LAST) begin
      div_cnt   <= '0;
      digit_idx <= digit_idx + 2'd1;
    end else begin
      div_cnt   <= div_cnt + DIV_W'(1);
    end
  end

  // Shadow the inputs at the last cycle of a frame so a frame never tears.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_min <= 6'd0;
      sh_sec <= 6'd0;
    end else if (frame_end) begin
      sh_min <= in_minutes;
      sh_sec <= in_seconds;
    end
  end

  // Blink phase generator; a blink sequence always begins in the ON phase.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fin_q     <= 1'b0;
      blink_cnt <= '0;
      blink_on  <= 1'b1;
    end else begin
      fin_q <= finish;
      if (!fin_q) begin
        blink_cnt <= '0;
        blink_on  <= 1'b1;
      end else if (blink_cnt == BLINK_LAST) begin
        blink_cnt <= '0;
        blink_on  <= ~blink_on;
      end else begin
        blink_cnt <= blink_cnt + BLINK_W'(1);
      end
    end
  end

  // Select the field for the current digit, convert to BCD and encode.
  always_comb begin
    field     = digit_idx[1] ? sh_min : sh_sec;
    tens_val  = field / 6'd10;
    ones_val  = field % 6'd10;
    digit_val = digit_idx[0] ? tens_val : ones_val;
    case (digit_val)
      6'd0:    seg_next = 7'h3F;
      6'd1:    seg_next = 7'h06;
      6'd2:    seg_next = 7'h5B;
      6'd3:    seg_next = 7'h4F;
      6'd4:    seg_next = 7'h66;
      6'd5:    seg_next = 7'h6D;
      6'd6:    seg_next = 7'h7D;
      6'd7:    seg_next = 7'h07;
      6'd8:    seg_next = 7'h7F;
      6'd9:    seg_next = 7'h6F;
      default: seg_next = 7'h40;
    endcase
    // A field above 59 shows dashes on both of its digits.
    if (field > 6'd59) begin
      seg_next = 7'h40;
    end
    an_next = 4'b0001 << digit_idx;
    dp_next = (digit_idx == 2'd2);
    if (!blink_on) begin
      seg_next = 7'h00;
      an_next  = 4'b0000;
      dp_next  = 1'b0;
    end
  end

  // Output register; polarity inversion for common-anode is applied here.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg <= {7{POL}};
      dp  <= POL;
      an  <= {4{POL}};
    end else begin
      seg <= seg_next ^ {7{POL}};
      dp  <= dp_next ^ POL;
      an  <= an_next ^ {4{POL}};
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_stopwatch_display_driver.sv
`default_nettype none
// ============================================================================
// Module      : tb_stopwatch_display_driver
// Description : Randomized self-checking bench for stopwatch_display_driver,
//               with both common-cathode and common-anode instances compared
//               against a behavioural display model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_stopwatch_display_driver;

  localparam int SD = 4;
  localparam int BD = 16;
  localparam int FRAME = 4 * SD;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [5:0] in_minutes = 6'd1;
  logic [5:0] in_seconds = 6'd24;
  logic       finish = 1'b0;
  logic [6:0] seg0, seg1;
  logic       dp0, dp1;
  logic [3:0] an0, an1;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  stopwatch_display_driver #(.SCAN_DIV(SD), .BLINK_DIV(BD), .COMMON_ANODE(0)) dut_cc (
    .clk(clk), .rst_n(rst_n), .in_minutes(in_minutes), .in_seconds(in_seconds),
    .finish(finish), .seg(seg0), .dp(dp0), .an(an0)
  );

  stopwatch_display_driver #(.SCAN_DIV(SD), .BLINK_DIV(BD), .COMMON_ANODE(1)) dut_ca (
    .clk(clk), .rst_n(rst_n), .in_minutes(in_minutes), .in_seconds(in_seconds),
    .finish(finish), .seg(seg1), .dp(dp1), .an(an1)
  );

  // Compare one observed value {seg,dp,an} against the expected one.
  task automatic check(input string tag, input logic [11:0] got, input logic [11:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got seg=%h dp=%b an=%b, expected seg=%h dp=%b an=%b",
               tag, $time, got[11:5], got[4], got[3:0], exp[11:5], exp[4], exp[3:0]);
    end
  endtask

  // ---------------- behavioural reference model ----------------
  logic [6:0] segtab [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                              7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

  // Active-high display pattern for a given digit position, field values and blink phase.
  function automatic logic [11:0] disp(input int idx, input int mn, input int sc, input bit on);
    int v;
    logic [6:0] s;
    if (!on) return 12'h000;
    v = (idx >= 2) ? mn : sc;
    if (v > 59) s = 7'h40;
    else        s = segtab[(idx % 2 == 0) ? (v % 10) : (v / 10)];
    return {s, 1'(idx == 2), 4'(1 << idx)};
  endfunction

  int m_n;          // edges since reset release
  int m_min, m_sec; // values shown in the current frame
  bit m_fq;         // finish as seen one cycle late
  int m_fk;         // consecutive edges spent with finish seen high
  logic [11:0] m_exp;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_n <= 0; m_min <= 0; m_sec <= 0; m_fq <= 1'b0; m_fk <= 0; m_exp <= 12'h000;
    end else begin
      m_exp <= disp((m_n / SD) % 4, m_min, m_sec, ((m_fk / BD) % 2) == 0);
      if (m_n % FRAME == FRAME - 1) begin
        m_min <= int'(in_minutes);
        m_sec <= int'(in_seconds);
      end
      m_fk  <= m_fq ? m_fk + 1 : 0;
      m_fq  <= finish;
      m_n   <= m_n + 1;
    end
  end

  // Continuous comparison away from the active edge.
  always @(negedge clk) begin
    check("cc_out", {seg0, dp0, an0}, m_exp);
    check("ca_out", {seg1, dp1, an1}, ~m_exp);
  end

  // Wait (bounded) until the model is scanning the given digit.
  task automatic wait_digit(input int idx);
    int k = 0;
    @(negedge clk);
    while (((m_n / SD) % 4) != idx && k < 100) begin
      @(negedge clk);
      k++;
    end
    n_cmp++;
    if (k >= 100) begin
      n_err++;
      $display("FAIL wait_digit: digit %0d never reached", idx);
    end
  endtask

  // Pulse reset asynchronously between edges and check outputs at once.
  task automatic async_reset;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_cc", {seg0, dp0, an0}, 12'h000);
    check("async_rst_ca", {seg1, dp1, an1}, 12'hFFF);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    // Reset held with 01:24 present, then release.
    repeat (3) @(negedge clk);
    check("reset_cc", {seg0, dp0, an0}, 12'h000);
    check("reset_ca", {seg1, dp1, an1}, 12'hFFF);
    rst_n = 1'b1;
    @(negedge clk);
    check("first_edge", {seg0, dp0, an0}, {7'h3F, 1'b0, 4'b0001});
    repeat (3 * FRAME) @(negedge clk);

    // Invalid minutes field.
    in_minutes = 6'd63;
    repeat (2 * FRAME) @(negedge clk);
    in_minutes = 6'd59;
    in_seconds = 6'd60;
    repeat (2 * FRAME) @(negedge clk);

    // Tearing: change value while digit 2 is being scanned.
    in_minutes = 6'd1; in_seconds = 6'd24;
    repeat (FRAME) @(negedge clk);
    wait_digit(2);
    in_minutes = 6'd0; in_seconds = 6'd59;
    repeat (2 * FRAME) @(negedge clk);

    // Blink, then release finish during an OFF phase.
    finish = 1'b1;
    repeat (40) @(negedge clk);
    begin
      int k = 0;
      while (((m_fk / BD) % 2) == 0 && k < 100) begin
        @(negedge clk);
        k++;
      end
    end
    repeat (3) @(negedge clk);
    finish = 1'b0;
    repeat (FRAME) @(negedge clk);

    // Async reset while digit 3 is scanned.
    wait_digit(3);
    async_reset();
    repeat (FRAME) @(negedge clk);

    // Randomized traffic.
    for (int i = 0; i < 60; i++) begin
      repeat ($urandom_range(1, 40)) @(negedge clk);
      case ($urandom_range(0, 9))
        0, 1, 2, 3: begin
          in_minutes = 6'($urandom_range(0, 59));
          in_seconds = 6'($urandom_range(0, 59));
        end
        4: begin
          in_minutes = 6'($urandom_range(0, 63));
          in_seconds = 6'($urandom_range(0, 63));
        end
        5, 6, 7: finish = ~finish;
        8: async_reset();
        default: in_seconds = 6'($urandom_range(0, 63));
      endcase
    end
    finish = 1'b0;
    repeat (2 * FRAME) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
